// File: rtl/fds_table_loader.sv
// Bus-side bulk loader for the FDS wavetable / mod table, sharing the audio register port with the CPU.
// Optional read-back check of wavetable loads is enabled with `define FDS_LOADER_VERIFY_EN.
module fds_table_loader #(
  parameter int SRC_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m2,
  input  logic        cpu_cs,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        start,
  input  logic        table_sel,
  output logic [5:0]  src_addr,
  input  logic [7:0]  src_data,
  output logic        fds_wr,
  output logic [15:0] fds_addr,
  output logic [7:0]  fds_data,
  input  logic [7:0]  fds_dout,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_FETCH, S_DATA,
`ifdef FDS_LOADER_VERIFY_EN
    S_VERIFY,
`endif
    S_POST, S_FIN
  } state_t;

  localparam logic [1:0] LAT = 2'(SRC_LAT);

  state_t      state, state_nxt;
  logic        m2_q;
  logic        slot_ok;
  logic        tsel;
  logic [5:0]  idx;
  logic [1:0]  lat_cnt;
  logic [5:0]  src_q;
  logic        error_q;
  logic [7:0]  sh4089, sh4087;
  logic        last_idx;
  logic        clobber;
  logic [15:0] unlock_addr;
  logic [7:0]  unlock_sh;
  logic        ldr_wr;
  logic [15:0] ldr_addr;
  logic [7:0]  ldr_data;
`ifdef FDS_LOADER_VERIFY_EN
  logic        vphase;
  logic        unused_bits;
  assign unused_bits = ^{src_data[7:6], fds_dout[7:6]};
`else
  logic        unused_bits;
  assign unused_bits = ^{src_data[7:6], fds_dout};
`endif

  // A loader write is only taken on an M2 rising edge the CPU is not using
  assign slot_ok     = m2 & ~m2_q & ~cpu_cs;
  assign last_idx    = tsel ? (idx == 6'd31) : (idx == 6'd63);
  assign unlock_addr = tsel ? 16'h4087 : 16'h4089;
  assign unlock_sh   = tsel ? sh4087 : sh4089;
  assign clobber     = (state == S_FETCH || state == S_DATA) && cpu_cs && cpu_wr &&
                       (cpu_addr == unlock_addr) && !cpu_data[7];
  assign src_addr    = idx;
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_FIN);
  assign error       = error_q;

  always_comb begin
    state_nxt = state;
    ldr_wr    = 1'b0;
    ldr_addr  = 16'h0000;
    ldr_data  = 8'h00;
    case (state)
      S_IDLE: if (start) state_nxt = S_PRE;
      S_PRE: begin
        ldr_wr   = 1'b1;
        ldr_addr = unlock_addr;
        ldr_data = {1'b1, unlock_sh[6:0]};
        if (slot_ok) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (lat_cnt == LAT) begin
`ifdef FDS_LOADER_VERIFY_EN
          state_nxt = vphase ? S_VERIFY : S_DATA;
`else
          state_nxt = S_DATA;
`endif
        end
      end
      S_DATA: begin
        ldr_wr   = 1'b1;
        ldr_addr = tsel ? 16'h4088 : (16'h4040 + {10'd0, idx});
        ldr_data = tsel ? {5'b0, src_q[2:0]} : {2'b00, src_q};
        if (slot_ok) begin
          if (!last_idx) state_nxt = S_FETCH;
`ifdef FDS_LOADER_VERIFY_EN
          else if (!tsel) state_nxt = S_FETCH;
`endif
          else state_nxt = S_POST;
        end
      end
`ifdef FDS_LOADER_VERIFY_EN
      S_VERIFY: begin
        ldr_addr = 16'h4040 + {10'd0, idx};
        if (slot_ok) state_nxt = last_idx ? S_POST : S_FETCH;
      end
`endif
      S_POST: begin
        ldr_wr   = 1'b1;
        ldr_addr = unlock_addr;
        ldr_data = unlock_sh;
        if (slot_ok) state_nxt = S_FIN;
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    if (cpu_cs) begin
      fds_wr   = cpu_wr;
      fds_addr = cpu_addr;
      fds_data = cpu_data;
    end else begin
      fds_wr   = ldr_wr;
      fds_addr = ldr_addr;
      fds_data = ldr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      m2_q    <= 1'b0;
      tsel    <= 1'b0;
      idx     <= 6'd0;
      lat_cnt <= 2'd0;
      error_q <= 1'b0;
      sh4089  <= 8'h00;
      sh4087  <= 8'h80;
`ifdef FDS_LOADER_VERIFY_EN
      vphase  <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      m2_q    <= m2;
      lat_cnt <= (state == S_FETCH) ? lat_cnt + 2'd1 : 2'd0;
      if (cpu_cs && cpu_wr && cpu_addr == 16'h4089) sh4089 <= cpu_data;
      if (cpu_cs && cpu_wr && cpu_addr == 16'h4087) sh4087 <= cpu_data;
      if (state == S_IDLE && start) begin
        tsel    <= table_sel;
        idx     <= 6'd0;
        error_q <= 1'b0;
`ifdef FDS_LOADER_VERIFY_EN
        vphase  <= 1'b0;
`endif
      end
      if (clobber) error_q <= 1'b1;
      if (state == S_DATA && slot_ok && !last_idx) idx <= idx + 6'd1;
`ifdef FDS_LOADER_VERIFY_EN
      // Wave loads rewind to entry 0 and read the table back before POST
      if (state == S_DATA && slot_ok && last_idx && !tsel) begin
        vphase <= 1'b1;
        idx    <= 6'd0;
      end
      if (state == S_VERIFY && slot_ok) begin
        if (fds_dout[5:0] != src_q) error_q <= 1'b1;
        if (!last_idx) idx <= idx + 6'd1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_FETCH && lat_cnt == LAT) src_q <= src_data[5:0];
  end

endmodule

// File: tb/tb_fds_table_loader.sv
// Directed bench for fds_table_loader: logs every register write the audio block would see on M2 rise.
module tb_fds_table_loader;
  logic        clk = 1'b0, reset = 1'b1, m2 = 1'b0;
  logic        cpu_cs = 1'b0, cpu_wr = 1'b0;
  logic [15:0] cpu_addr = 16'h0;
  logic [7:0]  cpu_data = 8'h0;
  logic        start = 1'b0, table_sel = 1'b0;
  logic [5:0]  src_addr;
  logic [7:0]  src_data = 8'h0;
  logic        fds_wr, busy, done, error;
  logic [15:0] fds_addr;
  logic [7:0]  fds_data, fds_dout;

  int vectors = 0, miscompares = 0;
  logic [23:0] log_q[$];
  logic [7:0]  wmem[64];
  logic        corrupt = 1'b0;
  logic        m2_d = 1'b0;

  fds_table_loader #(.SRC_LAT(1)) dut (
    .clk(clk), .reset(reset), .m2(m2), .cpu_cs(cpu_cs), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data), .start(start), .table_sel(table_sel),
    .src_addr(src_addr), .src_data(src_data), .fds_wr(fds_wr), .fds_addr(fds_addr),
    .fds_data(fds_data), .fds_dout(fds_dout), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;
  // M2 changes 1 ns after a clk rise; period 8 clks
  initial begin #6; forever #40 m2 = ~m2; end

  always @(posedge clk) begin
    m2_d     <= m2;
    src_data <= 8'hC0 | {2'b00, src_addr};
  end

  always @(negedge clk) begin
    if (m2 && !m2_d && fds_wr) begin
      log_q.push_back({fds_addr, fds_data});
      if (fds_addr[15:6] == 10'h101) wmem[fds_addr[5:0]] = fds_data;
    end
  end

  assign fds_dout = {2'b00, wmem[fds_addr[5:0]][5:0] ^ {5'b0, corrupt && (fds_addr == 16'h4047)}};

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(posedge m2);
    cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_addr = a; cpu_data = d;
    @(posedge clk); #1;
    cpu_cs = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic pulse_start(input logic sel);
    @(negedge clk); start = 1'b1; table_sel = sel;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(output logic seen, output logic err);
    seen = 1'b0; err = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; err = error; break; end
    end
  endtask

  task automatic wait_log(input int n, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (log_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, error, fds_wr} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_status: got busy/done/error/wr=%b want 0000", {busy, done, error, fds_wr});
    end
    vectors++;
    if ({fds_addr, fds_data} !== 24'h0) begin
      miscompares++; $display("FAIL reset_port: got %h want 000000", {fds_addr, fds_data});
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, fds_wr, fds_addr} !== 18'h0) begin
      miscompares++; $display("FAIL idle_port: got %h want 0", {busy, fds_wr, fds_addr});
    end
  endtask

  task automatic test_wave_load(input string nm);
    logic seen, err;
    logic [23:0] exp_v;
    log_q.delete();
    pulse_start(1'b0);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL %s_busy: got %b want 1", nm, busy); end
    wait_done(seen, err);
    vectors++;
    if (seen !== 1'b1 || err !== 1'b0) begin
      miscompares++; $display("FAIL %s_done: got done=%b error=%b want done=1 error=0", nm, seen, err);
    end
    @(negedge clk);
    vectors++;
    if ({done, busy} !== 2'b00) begin miscompares++; $display("FAIL %s_after_fin: got done/busy=%b want 00", nm, {done, busy}); end
    vectors++;
    if (log_q.size() != 66) begin miscompares++; $display("FAIL %s_slots: got %0d want 66", nm, log_q.size()); end
    for (int k = 0; k < 66 && k < log_q.size(); k++) begin
      if (k == 0) exp_v = 24'h408980;
      else if (k == 65) exp_v = 24'h408900;
      else exp_v = {16'h4040 + 16'(k - 1), 8'(k - 1)};
      vectors++;
      if (log_q[k] !== exp_v) begin miscompares++; $display("FAIL %s_slot%0d: got %h want %h", nm, k, log_q[k], exp_v); end
    end
  endtask

  task automatic test_mod_load;
    logic seen, err;
    logic [23:0] exp_v;
    cpu_write(16'h4087, 8'h05);
    log_q.delete();
    pulse_start(1'b1);
    wait_done(seen, err);
    vectors++;
    if (seen !== 1'b1 || err !== 1'b0) begin
      miscompares++; $display("FAIL mod_done: got done=%b error=%b want done=1 error=0", seen, err);
    end
    vectors++;
    if (log_q.size() != 34) begin miscompares++; $display("FAIL mod_slots: got %0d want 34", log_q.size()); end
    for (int k = 0; k < 34 && k < log_q.size(); k++) begin
      if (k == 0) exp_v = 24'h408785;
      else if (k == 33) exp_v = 24'h408705;
      else exp_v = {16'h4088, 8'((k - 1) & 7)};
      vectors++;
      if (log_q[k] !== exp_v) begin miscompares++; $display("FAIL mod_slot%0d: got %h want %h", k, log_q[k], exp_v); end
    end
  endtask

  task automatic test_cpu_collision;
    logic seen, err, ok;
    logic [23:0] exp_v;
    log_q.delete();
    pulse_start(1'b0);
    wait_log(11, ok);
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL coll_progress: got %0d slots want 11", log_q.size()); end
    cpu_write(16'h4082, 8'h55);
    wait_done(seen, err);
    vectors++;
    if (seen !== 1'b1 || err !== 1'b0) begin
      miscompares++; $display("FAIL coll_done: got done=%b error=%b want done=1 error=0", seen, err);
    end
    vectors++;
    if (log_q.size() != 67) begin miscompares++; $display("FAIL coll_slots: got %0d want 67", log_q.size()); end
    for (int k = 0; k < 67 && k < log_q.size(); k++) begin
      if (k == 0) exp_v = 24'h408980;
      else if (k <= 10) exp_v = {16'h4040 + 16'(k - 1), 8'(k - 1)};
      else if (k == 11) exp_v = 24'h408255;
      else if (k <= 65) exp_v = {16'h4040 + 16'(k - 2), 8'(k - 2)};
      else exp_v = 24'h408900;
      vectors++;
      if (log_q[k] !== exp_v) begin miscompares++; $display("FAIL coll_slot%0d: got %h want %h", k, log_q[k], exp_v); end
    end
  endtask

  task automatic test_clobber;
    logic seen, err, ok;
    log_q.delete();
    pulse_start(1'b0);
    wait_log(20, ok);
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL clob_progress: got %0d slots want 20", log_q.size()); end
    cpu_write(16'h4089, 8'h02);
    wait_done(seen, err);
    vectors++;
    if (seen !== 1'b1 || err !== 1'b1) begin
      miscompares++; $display("FAIL clob_done: got done=%b error=%b want done=1 error=1", seen, err);
    end
    vectors++;
    if (log_q.size() != 67 || log_q[log_q.size() - 1] !== 24'h408902) begin
      miscompares++; $display("FAIL clob_post: got %0d slots last %h want 67 slots last 408902",
                              log_q.size(), log_q[log_q.size() - 1]);
    end
    repeat (5) @(negedge clk);
    vectors++;
    if (error !== 1'b1) begin miscompares++; $display("FAIL clob_hold: got error=%b want 1", error); end
  endtask

  task automatic test_reset_mid_load;
    logic ok;
    int n;
    pulse_start(1'b0);
    vectors++;
    if (error !== 1'b0) begin miscompares++; $display("FAIL rst_err_clr: got error=%b want 0", error); end
    wait_log(31, ok);
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL rst_progress: got %0d slots want 31", log_q.size()); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if ({busy, done, error} !== 3'b000) begin
      miscompares++; $display("FAIL rst_status: got busy/done/error=%b want 000", {busy, done, error});
    end
    n = log_q.size();
    repeat (40) @(negedge clk);
    vectors++;
    if (log_q.size() != n || busy !== 1'b0) begin
      miscompares++; $display("FAIL rst_quiet: got %0d new slots busy=%b want 0 new busy=0", log_q.size() - n, busy);
    end
    test_wave_load("reload");
  endtask

`ifdef FDS_LOADER_VERIFY_EN
  task automatic test_verify_corrupt;
    logic seen, err;
    corrupt = 1'b1;
    log_q.delete();
    pulse_start(1'b0);
    wait_done(seen, err);
    vectors++;
    if (seen !== 1'b1 || err !== 1'b1) begin
      miscompares++; $display("FAIL verify_err: got done=%b error=%b want done=1 error=1", seen, err);
    end
    vectors++;
    if (log_q.size() != 66 || log_q[log_q.size() - 1] !== 24'h408900) begin
      miscompares++; $display("FAIL verify_post: got %0d slots last %h want 66 slots last 408900",
                              log_q.size(), log_q[log_q.size() - 1]);
    end
    corrupt = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 64; i++) wmem[i] = 8'h00;
    test_reset();
    test_wave_load("wave");
    test_mod_load();
    test_cpu_collision();
    test_clobber();
    test_reset_mid_load();
`ifdef FDS_LOADER_VERIFY_EN
    test_verify_corrupt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fds_table_loader.md
Name: fds_table_loader

Overview:
- Bus-side sequencer and arbiter in front of the FDS audio register port.
- Bulk-loads the 64-entry wavetable or the 32-entry modulation table from a local source RAM, for NSF playback and savestate restore.
- Runs the required unlock, data and restore register protocol, one write per M2 rising edge.
- Shares the audio register port with the CPU; CPU accesses always win.

Parameters:
- SRC_LAT, 1, source RAM read latency in clk cycles (1 or 2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- m2  in  1  CPU M2 phase; the audio block samples writes on its rising edge
- cpu_cs  in  1  CPU access to 0x4040-0x4097 this cycle
- cpu_wr  in  1  CPU write strobe
- cpu_addr  in  16  CPU address
- cpu_data  in  8  CPU write data
- start  in  1  single-cycle load request
- table_sel  in  1  0 = wavetable (64 entries), 1 = mod table (32 entries); sampled with start
- src_addr  out  6  source RAM address
- src_data  in  8  source RAM data, valid SRC_LAT cycles after src_addr
- fds_wr  out  1  to audio wr
- fds_addr  out  16  to audio addr_in
- fds_data  out  8  to audio data_in
- fds_dout  in  8  from audio data_out (used only with the optional feature)
- busy  out  1  load in progress
- done  out  1  one-cycle pulse at end of load
- error  out  1  status of last load; valid with done, held until next start

Behaviour:
- Edge detect: m2_rise = m2 & ~m2_q, with m2_q registered on clk.
- Arbitration, combinational:
  - cpu_cs=1: fds_addr/fds_data/fds_wr = cpu_addr/cpu_data/cpu_wr.
  - Otherwise the loader drives the port; fds_wr = ldr_wr.
  - Idle and cpu_cs=0: fds_addr=0, fds_data=0, fds_wr=0.
- Slot rule:
  - A loader write completes only on a clk where m2_rise=1, cpu_cs=0 and ldr_wr=1.
  - If cpu_cs=1 on m2_rise, the write is retried at the next m2_rise. No loss, no duplicate.
- Shadows:
  - sh4089 and sh4087 capture cpu_data on CPU writes to 0x4089 and 0x4087 (cpu_cs & cpu_wr).
  - Reset values: sh4089=0x00, sh4087=0x80.
- States: IDLE -> PRE -> FETCH <-> DATA -> POST -> FIN -> IDLE.
  - IDLE: busy=0. start=1 latches table_sel, sets idx=0, clears error, goes to PRE. start while busy is ignored.
  - PRE:
    - Wave load: write 0x4089 = {1, sh4089[6:0]} (wave write enable).
    - Mod load: write 0x4087 = {1, sh4087[6:0]} (mod halt).
  - FETCH: drive src_addr=idx, wait SRC_LAT cycles, latch src_data, go to DATA.
  - DATA:
    - Wave load: write 0x4040+idx with data {2'b00, src[5:0]}.
    - Mod load: write 0x4088 with data {5'b0, src[2:0]}.
    - Each completed write increments idx. At idx = last (63 or 31) go to POST, otherwise FETCH.
    - Fetch latency is hidden within the M2 period; at most one write per m2_rise.
  - POST: write back the current sh4089 or sh4087 unmodified. This restores the CPU's wren and mod-halt settings, including any CPU changes made during the load.
  - FIN: done=1 for one clk, then IDLE.
- Mod table placement: entries land sequentially from the modulator's current table position. 32 writes cover every slot, and the table rotation is defined by that start position.
- Clobber detection: a CPU write that disables the unlock during DATA sets error=1 and completes the load normally (POST still runs).
  - Wave load: CPU write to 0x4089 with bit7=0.
  - Mod load: CPU write to 0x4087 with bit7=0.
- busy=1 from the clk after start through FIN inclusive.
- Reset mid-load: immediate IDLE, no POST write, busy/done/error=0, shadows reset. The audio block resets in the same cycle.

Optional Feature:
- Macro: FDS_LOADER_VERIFY_EN.
- Defined:
  - Wave loads only: insert VERIFY between the last DATA write and POST.
  - VERIFY drives fds_addr=0x4040+i with fds_wr=0 for i=0..63, one address per m2_rise slot (same arbitration).
  - Compares fds_dout[5:0] against src_data[5:0] refetched per entry.
  - Any mismatch sets error=1.
  - Mod loads skip VERIFY.
- Undefined: no VERIFY state; fds_dout is unused; wave load takes 66 slots.

Test Plan:
- Wave load, cpu_cs=0, source i -> 0xC0|i: exactly 66 fds_wr slots.
  - Slot 1: 0x4089 = 0x80.
  - Slots 2-65: 0x4040+i = i.
  - Slot 66: 0x4089 = 0x00.
  - Then done pulse, error=0.
- Mod load after CPU writes 0x4087 = 0x05:
  - Slot 1: 0x4087 = 0x85.
  - Then 32 writes to 0x4088 with data[7:3]=0.
  - Final write: 0x4087 = 0x05.
- CPU write 0x4082=0x55 coinciding with the loader's entry-10 slot: 0x4082 passes through, entry 10 lands on the next m2_rise, no entry repeated or skipped.
- CPU writes 0x4089 = 0x02 during DATA: error=1 at done, POST writes 0x4089 = 0x02.
- Reset asserted at entry 30: busy=0 next clk, no further fds_wr; a new start then performs a full 66-slot load.
- With FDS_LOADER_VERIFY_EN, audio model corrupting entry 7: error=1, POST still issued.
